// File: rtl/io_bus_master.sv
// Single-outstanding bus master: IDLE -> REQ (arbitrate) -> XFER (one data phase) -> DONE.
// Optional grant timeout is enabled by defining IO_BUS_MASTER_TIMEOUT_EN.

`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`endif
`ifndef IO_BUS_CTRL_TYPE_B
`define IO_BUS_CTRL_TYPE_B 1
`endif
`ifndef IO_BUS_CTRL_TYPE_H
`define IO_BUS_CTRL_TYPE_H 2
`endif
`ifndef IO_BUS_CTRL_UNSIGNED
`define IO_BUS_CTRL_UNSIGNED 3
`endif
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module io_bus_master #(
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          we,
  input  logic                          type_b,
  input  logic                          type_h,
  input  logic                          is_unsigned,
  input  logic [`IO_BUS_WIDTH_ADDR-1:0] addr_in,
  input  logic [`IO_BUS_WIDTH_DATA-1:0] wdata,
  output logic                          ready,
  output logic                          done,
  output logic [`IO_BUS_WIDTH_DATA-1:0] rdata,
  output logic                          err,
  output logic                          BR,
  input  logic                          BG,
  output logic [`IO_BUS_WIDTH_ADDR-1:0] addr,
  output logic [`IO_BUS_WIDTH_CTRL-1:0] ctrl,
  inout  wire  [`IO_BUS_WIDTH_DATA-1:0] data
);

  if (GRANT_TIMEOUT < 2 || GRANT_TIMEOUT > 255) begin : g_bad_timeout
    $error("io_bus_master: GRANT_TIMEOUT must be within 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic                          we_q, we_d;
  logic                          type_b_q, type_b_d;
  logic                          type_h_q, type_h_d;
  logic                          unsigned_q, unsigned_d;
  logic [`IO_BUS_WIDTH_ADDR-1:0] addr_lat_q, addr_lat_d;
  logic [`IO_BUS_WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [`IO_BUS_WIDTH_DATA-1:0] rdata_q, rdata_d;
  logic                          ready_q, ready_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          br_q, br_d;
  logic                          drive_q, drive_d;
  logic [`IO_BUS_WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [`IO_BUS_WIDTH_CTRL-1:0] ctrl_q, ctrl_d;

`ifdef IO_BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(GRANT_TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    type_b_d   = type_b_q;
    type_h_d   = type_h_q;
    unsigned_d = unsigned_q;
    addr_lat_d = addr_lat_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          type_b_d   = type_b;
          type_h_d   = type_h;
          unsigned_d = is_unsigned;
          addr_lat_d = addr_in;
          wdata_d    = wdata;
          state_d    = S_REQ;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_REQ: begin
        if (BG) begin
          state_d = S_XFER;
        end
`ifdef IO_BUS_MASTER_TIMEOUT_EN
        // A grant arriving on the limit cycle takes priority over the abort.
        else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_XFER: begin
        if (BG) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = data;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus-facing outputs are decoded from the next state so they are registered.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    br_d    = (state_d == S_REQ) || (state_d == S_XFER);
    drive_d = (state_d == S_XFER) && we_d;
    addr_d  = '0;
    ctrl_d  = '0;
    if (state_d == S_XFER) begin
      addr_d                          = addr_lat_d;
      ctrl_d[`IO_BUS_CTRL_WE]         = we_d ? `IO_CTRL_WRITE : `IO_CTRL_READ;
      ctrl_d[`IO_BUS_CTRL_TYPE_B]     = type_b_d;
      ctrl_d[`IO_BUS_CTRL_TYPE_H]     = type_h_d;
      ctrl_d[`IO_BUS_CTRL_UNSIGNED]   = unsigned_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      type_b_q   <= 1'b0;
      type_h_q   <= 1'b0;
      unsigned_q <= 1'b0;
      addr_lat_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      br_q       <= 1'b0;
      drive_q    <= 1'b0;
      addr_q     <= '0;
      ctrl_q     <= '0;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      type_b_q   <= type_b_d;
      type_h_q   <= type_h_d;
      unsigned_q <= unsigned_d;
      addr_lat_q <= addr_lat_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      br_q       <= br_d;
      drive_q    <= drive_d;
      addr_q     <= addr_d;
      ctrl_q     <= ctrl_d;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;
  assign BR    = br_q;
  assign addr  = addr_q;
  assign ctrl  = ctrl_q;
  assign rdata = rdata_q;
  assign data  = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_io_bus_master.sv
// Randomized bench for io_bus_master: the bench acts as arbiter and memory responder
// and predicts every bus cycle from the grant schedule it chooses per transaction.

`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`endif
`ifndef IO_BUS_CTRL_TYPE_B
`define IO_BUS_CTRL_TYPE_B 1
`endif
`ifndef IO_BUS_CTRL_TYPE_H
`define IO_BUS_CTRL_TYPE_H 2
`endif
`ifndef IO_BUS_CTRL_UNSIGNED
`define IO_BUS_CTRL_UNSIGNED 3
`endif

module tb_io_bus_master;
  localparam int unsigned AW = `IO_BUS_WIDTH_ADDR;
  localparam int unsigned DW = `IO_BUS_WIDTH_DATA;
  localparam int unsigned CW = `IO_BUS_WIDTH_CTRL;
  localparam int unsigned GT = 16;

  logic          clk = 1'b0;
  logic          rst, req, we, type_b, type_h, is_unsigned, BG;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata;
  logic          ready, done, err, BR;
  logic [DW-1:0] rdata;
  logic [AW-1:0] addr;
  logic [CW-1:0] ctrl;
  wire  [DW-1:0] data;

  logic          resp_en;
  logic [DW-1:0] resp_data;
  assign data = resp_en ? resp_data : 'z;

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rdata;

  always #5 clk = ~clk;

  io_bus_master #(.GRANT_TIMEOUT(GT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .type_b(type_b), .type_h(type_h),
    .is_unsigned(is_unsigned), .addr_in(addr_in), .wdata(wdata), .ready(ready),
    .done(done), .rdata(rdata), .err(err), .BR(BR), .BG(BG), .addr(addr),
    .ctrl(ctrl), .data(data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic scramble_inputs();
    addr_in     = AW'($urandom);
    wdata       = DW'($urandom);
    we          = 1'($urandom);
    type_b      = 1'($urandom);
    type_h      = 1'($urandom);
    is_unsigned = 1'($urandom);
  endtask

  // One idle cycle: bench drives a random pattern on data, master must be quiet.
  task automatic idle_cycle();
    @(negedge clk);
    resp_en   = 1'b1;
    resp_data = DW'($urandom);
    #1;
    check("idle_ready", ready, 1);
    check("idle_br", BR, 0);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_addr", addr, 0);
    check("idle_ctrl", ctrl, 0);
    check("idle_data", data, resp_data);
    check("idle_rdata", rdata, exp_rdata);
  endtask

  // g: REQ cycles with BG=0 before grant; s: XFER cycles stalled with BG=0.
  task automatic run_txn(input logic t_we, input logic t_b, input logic t_h, input logic t_u,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int unsigned g, input int unsigned s, input bit junk);
    int unsigned   last;
    logic          xfer;
    logic [CW-1:0] exp_ctrl;
    last = g + s + 2;
    exp_ctrl = '0;
    exp_ctrl[`IO_BUS_CTRL_WE]       = t_we;
    exp_ctrl[`IO_BUS_CTRL_TYPE_B]   = t_b;
    exp_ctrl[`IO_BUS_CTRL_TYPE_H]   = t_h;
    exp_ctrl[`IO_BUS_CTRL_UNSIGNED] = t_u;
    idle_cycle();
    req = 1'b1; we = t_we; type_b = t_b; type_h = t_h; is_unsigned = t_u;
    addr_in = a; wdata = wd; BG = 1'($urandom);
    for (int unsigned c = 0; c <= last; c++) begin
      @(negedge clk);
      xfer = (c >= g + 1) && (c <= g + 1 + s);
      if (xfer && t_we) begin
        resp_en = 1'b0;
      end else begin
        resp_en   = 1'b1;
        resp_data = xfer ? mem_rd(a) : DW'($urandom);
      end
      #1;
      check("br", BR, (c < last) ? 1 : 0);
      check("done", done, (c == last) ? 1 : 0);
      check("ready_busy", ready, 0);
      check("err_quiet", err, 0);
      check("addr", addr, xfer ? a : '0);
      check("ctrl", ctrl, xfer ? exp_ctrl : '0);
      check("data", data, (xfer && t_we) ? wd : resp_data);
      check("rdata", rdata, exp_rdata);
      if (c == g + 1 + s) begin
        if (t_we) mem[a] = wd;
        else exp_rdata = mem_rd(a);
      end
      if (c < g) BG = 1'b0;
      else if (c == g) BG = 1'b1;
      else if (c <= g + s) BG = 1'b0;
      else if (c == g + s + 1) BG = 1'b1;
      else BG = 1'($urandom);
      scramble_inputs();
      req = (junk && c < last) ? 1'($urandom) : 1'b0;
      if (junk && c == 0) begin
        req = 1'b1;
        addr_in = AW'(32'h20);
      end
    end
    req = 1'b0;
  endtask

  task automatic random_txn();
    int unsigned g, s;
    g = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 2);
    s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            AW'({$urandom_range(0, 15), 2'b00}), DW'($urandom) | DW'(1), g, s, 1'($urandom));
  endtask

  initial begin
    logic [DW-1:0] wd;
    rst = 1'b1; req = 1'b0; BG = 1'b0; we = 1'b0; type_b = 1'b0; type_h = 1'b0;
    is_unsigned = 1'b0; addr_in = '0; wdata = '0;
    resp_en = 1'b1; resp_data = DW'($urandom);
    exp_rdata = '0;
    for (int unsigned i = 0; i < 16; i++) mem[AW'(i * 4)] = DW'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_br", BR, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", addr, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_data", data, resp_data);
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 1'b0, 1'b0, AW'(32'h10), DW'(32'hDEADBEEF), 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, AW'(32'h10), '0, 0, 0, 1'b0);
    check("load_back", rdata, DW'(32'hDEADBEEF));
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, AW'(32'h10), '0, 5, 0, 1'b0);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, AW'(32'h10), '0, 1, 0, 1'b1);
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, AW'(32'h14), DW'(32'h12345678), 15, 0, 1'b0);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, AW'(32'h14), '0, 0, 2, 1'b0);

    // Reset during the data phase of a store: the responder does not commit it.
    idle_cycle();
    wd = DW'(32'hA5A5F00F);
    req = 1'b1; we = 1'b1; type_b = 1'b0; type_h = 1'b0; is_unsigned = 1'b0;
    addr_in = AW'(32'h24); wdata = wd; BG = 1'b1;
    @(negedge clk);
    resp_en = 1'b1; resp_data = DW'($urandom);
    req = 1'b0;
    @(negedge clk);
    resp_en = 1'b0;
    #1;
    check("rstx_store_data", data, wd);
    rst = 1'b1;
    @(negedge clk);
    resp_en = 1'b1; resp_data = DW'($urandom);
    #1;
    check("rstx_br", BR, 0);
    check("rstx_done", done, 0);
    check("rstx_ready", ready, 1);
    check("rstx_addr", addr, 0);
    check("rstx_data", data, resp_data);
    check("rstx_rdata", rdata, 0);
    exp_rdata = '0;
    rst = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, AW'(32'h10), '0, 0, 0, 1'b0);

`ifdef IO_BUS_MASTER_TIMEOUT_EN
    idle_cycle();
    req = 1'b1; we = 1'b0; addr_in = AW'(32'h18); BG = 1'b0;
    for (int unsigned c = 0; c <= GT; c++) begin
      @(negedge clk);
      resp_en = 1'b1; resp_data = DW'($urandom);
      #1;
      req = 1'b0;
      if (c < GT) begin
        check("to_wait_br", BR, 1);
        check("to_wait_err", err, 0);
        check("to_wait_ready", ready, 0);
      end else begin
        check("to_err", err, 1);
        check("to_br", BR, 0);
        check("to_ready", ready, 1);
      end
      check("to_done", done, 0);
      check("to_data", data, resp_data);
      check("to_rdata", rdata, exp_rdata);
    end
`else
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, AW'(32'h10), '0, 40, 0, 1'b1);
`endif

    for (int unsigned n = 0; n < 200; n++) random_txn();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 GRANT_TIMEOUT, 16, max cycles spent waiting for BG before abort (only with IO_BUS_MASTER_TIMEOUT_EN); legal range 2..255.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  1  core request; accepted only while ready=1.
REQ-005 we  input  1  1=store, 0=load.
REQ-006 type_b / type_h / is_unsigned  input  1 each  access size and sign, copied to ctrl.
REQ-007 addr_in  input  `IO_BUS_WIDTH_ADDR  transaction address.
REQ-008 wdata  input  `IO_BUS_WIDTH_DATA  store data.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  `IO_BUS_WIDTH_DATA  load result, held until next load completes.
REQ-012 err  output  1  one-cycle grant-timeout pulse.
REQ-013 BR  output  1  bus request to arbiter.
REQ-014 BG  input  1  bus grant from arbiter.
REQ-015 addr  output  `IO_BUS_WIDTH_ADDR  bus address.
REQ-016 ctrl  output  `IO_BUS_WIDTH_CTRL  bus control; bits `IO_BUS_CTRL_WE/_TYPE_B/_TYPE_H/_UNSIGNED.
REQ-017 data  inout  `IO_BUS_WIDTH_DATA  shared bus data.

Function
REQ-018 States IDLE, REQ, XFER, DONE; 2-bit encoded register.
REQ-019 IDLE: req=1 latches we, type_b, type_h, is_unsigned, addr_in, wdata into internal regs and moves to REQ; req=0 stays.
REQ-020 Inputs changing after acceptance shall not affect the running transaction.
REQ-021 REQ: BR=1; BG=1 sampled at edge -> XFER; else stay.
REQ-022 XFER: BR=1; addr and ctrl driven from latched regs; ctrl[`IO_BUS_CTRL_WE] = `IO_CTRL_WRITE for store, `IO_CTRL_READ for load.
REQ-023 XFER store: data driven with latched wdata; XFER load: data high-Z and sampled into rdata at the edge leaving XFER.
REQ-024 XFER lasts exactly one cycle when BG=1; BG=0 in XFER holds XFER (no data capture, no exit) until BG=1.
REQ-025 DONE: done=1, BR=0, data high-Z; unconditionally -> IDLE next cycle.
REQ-026 Outside XFER: addr=0, ctrl=0, data high-Z; data never driven during loads.
REQ-027 Latency with BG held high: req accepted at edge T, XFER in cycle T+1..T+2, done high in cycle after XFER; minimum 3 cycles req-to-done.
REQ-028 Stores leave rdata unchanged; rdata is raw bus value (responder performs extension).
REQ-029 req asserted during REQ/XFER/DONE ignored; back-to-back transactions require return to IDLE (one ready cycle between).

Reset
REQ-030 rst=1 at edge: state IDLE, BR=0, done=0, err=0, rdata=0, addr=0, ctrl=0, data high-Z, timeout counter 0.
REQ-031 rst mid-transaction aborts it with no done/err pulse; a store in XFER may or may not have been written by the responder.

Configuration
REQ-032 Macro IO_BUS_MASTER_TIMEOUT_EN defined: 8-bit counter clears on entering REQ, increments each REQ cycle with BG=0; reaching GRANT_TIMEOUT-1 with BG still 0 -> err=1 one cycle, BR=0, return IDLE, rdata unchanged.
REQ-033 BG=1 on the same cycle the counter hits limit: grant wins, no err.
REQ-034 Macro undefined: no counter logic, REQ waits indefinitely, err tied 0.

Verification
REQ-035 Store: BG=1, req, we=1, addr_in=0x10, wdata=0xDEADBEEF -> one XFER cycle with data=0xDEADBEEF, ctrl WE=write; done 3 cycles after req; RAM word 0x10 reads back 0xDEADBEEF.
REQ-036 Load: after REQ-035, req, we=0, addr_in=0x10 -> data high-Z from master, rdata=0xDEADBEEF with done.
REQ-037 Grant delay: BG held 0 for 5 cycles after req -> BR high throughout, no bus drive, done 5 cycles later than REQ-035 timing.
REQ-038 Timeout (macro on, GRANT_TIMEOUT=16): BG never asserted -> err pulse exactly 16 cycles after entering REQ, BR falls, ready returns, done never pulses.
REQ-039 Reset in XFER of a store: rst=1 -> next cycle BR=0, data high-Z, no done; subsequent load completes normally.
REQ-040 Ignore: req pulsed during REQ with different addr_in=0x20 -> transaction completes using original address 0x10.
